// File: rtl/cpu.sv
// Multicycle 16-bit RISC core: instruction register, 8x16 register file, shifter/ALU datapath and controller FSM.
// Latency 2..6 edges from s to w; no backpressure, s is only honoured while w=1 and IR loads whenever load=1.

module cpu_shifter (
    input  logic [15:0] dat,
    input  logic [1:0]  sh,
    output logic [15:0] res
);
    always_comb begin
        case (sh)
            2'b01:   res = {dat[14:0], 1'b0};
            2'b10:   res = {1'b0, dat[15:1]};
            2'b11:   res = {dat[15], dat[15:1]};
            default: res = dat;
        endcase
    end
endmodule

module cpu_alu (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic [15:0] res,
    output logic        n,
    output logic        v,
    output logic        z
);
    logic [15:0] diff;

    always_comb begin
        diff = a - b;
        case (op)
            2'b00:   res = a + b;
            2'b01:   res = diff;
            2'b10:   res = a & b;
            default: res = ~b;
        endcase
    end

    // Overflow is only meaningful for the subtract path used by CMP.
    assign n = res[15];
    assign z = (res == 16'd0);
    assign v = (a[15] ^ b[15]) & (diff[15] ^ a[15]);
endmodule

module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_vld,
    input  logic [2:0]  wr_idx,
    input  logic [15:0] wr_dat,
    input  logic [2:0]  rd_idx_a,
    input  logic [2:0]  rd_idx_b,
    output logic [15:0] rd_dat_a,
    output logic [15:0] rd_dat_b
);
    logic [15:0] regs [8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld) begin
            regs[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat_a = regs[rd_idx_a];
    assign rd_dat_b = regs[rd_idx_b];
endmodule

module cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } instr_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WRITEREG,
        S_WRITEIMM
    } state_t;

    instr_t      ir;
    state_t      state;
    logic [15:0] a_q, b_q, c_q;
    logic        n_q, v_q, z_q;
    logic [15:0] b_sh, alu_res, rn_dat, rm_dat, imm_sx, wr_dat;
    logic [7:0]  imm8;
    logic        alu_n, alu_v, alu_z;
    logic        wr_vld;
    logic [2:0]  wr_idx;
    logic        is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (load) begin
            ir <= in;
        end
    end

    assign imm8   = {ir.rd, ir.sh, ir.rm};
    assign imm_sx = {{8{imm8[7]}}, imm8};

    assign is_mov_imm = (ir.opcode == 3'b110) && (ir.op == 2'b10);
    assign is_mov_reg = (ir.opcode == 3'b110) && (ir.op == 2'b00);
    assign is_mvn     = (ir.opcode == 3'b101) && (ir.op == 2'b11);
    assign is_cmp     = (ir.opcode == 3'b101) && (ir.op == 2'b01);
    assign is_alu3    = (ir.opcode == 3'b101) && (ir.op != 2'b11);

    // The immediate path writes Rn; every ALU result goes to Rd via C.
    assign wr_vld = (state == S_WRITEREG) || (state == S_WRITEIMM);
    assign wr_idx = (state == S_WRITEIMM) ? ir.rn : ir.rd;
    assign wr_dat = (state == S_WRITEIMM) ? imm_sx : c_q;

    cpu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_vld   (wr_vld),
        .wr_idx   (wr_idx),
        .wr_dat   (wr_dat),
        .rd_idx_a (ir.rn),
        .rd_idx_b (ir.rm),
        .rd_dat_a (rn_dat),
        .rd_dat_b (rm_dat)
    );

    cpu_shifter u_shifter (
        .dat (b_q),
        .sh  (ir.sh),
        .res (b_sh)
    );

    // MOV reg shares the ADD path (op=00) with A forced to zero in GETB.
    cpu_alu u_alu (
        .a   (a_q),
        .b   (b_sh),
        .op  (ir.op),
        .res (alu_res),
        .n   (alu_n),
        .v   (alu_v),
        .z   (alu_z)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_WAIT;
            w     <= 1'b1;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            n_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (s) begin
                        state <= S_DECODE;
                        w     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_mov_imm) begin
                        state <= S_WRITEIMM;
                    end else if (is_mov_reg || is_mvn) begin
                        state <= S_GETB;
                    end else if (is_alu3) begin
                        state <= S_GETA;
                    end else begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end
                end
                S_GETA: begin
                    a_q   <= rn_dat;
                    state <= S_GETB;
                end
                S_GETB: begin
                    b_q <= rm_dat;
                    if (is_mov_reg) begin
                        a_q <= '0;
                    end
                    state <= S_ALU;
                end
                S_ALU: begin
                    c_q <= alu_res;
                    if (is_cmp) begin
                        n_q   <= alu_n;
                        v_q   <= alu_v;
                        z_q   <= alu_z;
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end else begin
                        state <= S_WRITEREG;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
            endcase
        end
    end

    assign out = c_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;
endmodule

// File: tb/tb_cpu.sv
// Randomized bench for cpu against an instruction-level reference model.
module tb_cpu;
    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        N, V, Z, w;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_reg [8];
    logic [15:0] m_c;
    logic        m_n, m_v, m_z;

    cpu dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .in    (in),
        .out   (out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .w     (w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_c = '0;
        m_n = 1'b0;
        m_v = 1'b0;
        m_z = 1'b0;
    endtask

    // Executes one instruction on the model and returns the expected s-to-w edge count.
    task automatic model_exec(input logic [15:0] ins, output int lat);
        logic [15:0]        rm_v, rn_v, bsh, res;
        logic signed [15:0] sx;
        int                 sd;
        rm_v = m_reg[ins[2:0]];
        rn_v = m_reg[ins[10:8]];
        case (ins[4:3])
            2'd1:    bsh = 16'(32'(rm_v) * 2);
            2'd2:    bsh = rm_v / 16'd2;
            2'd3:    bsh = $signed(rm_v) >>> 1;
            default: bsh = rm_v;
        endcase
        lat = 2;
        if (ins[15:11] == 5'b11010) begin
            sx = $signed(ins[7:0]);
            m_reg[ins[10:8]] = sx;
            lat = 3;
        end else if (ins[15:11] == 5'b11000) begin
            m_c = bsh;
            m_reg[ins[7:5]] = bsh;
            lat = 5;
        end else if (ins[15:13] == 3'b101) begin
            case (ins[12:11])
                2'd0: begin res = rn_v + bsh; lat = 6; end
                2'd1: begin
                    res = rn_v - bsh;
                    sd  = int'($signed(rn_v)) - int'($signed(bsh));
                    m_v = (sd > 32767) || (sd < -32768);
                    m_n = res[15];
                    m_z = (res == 16'd0);
                    lat = 5;
                end
                2'd2: begin res = rn_v & bsh; lat = 6; end
                default: begin res = ~bsh; lat = 5; end
            endcase
            m_c = res;
            if (ins[12:11] != 2'd1) m_reg[ins[7:5]] = res;
        end
    endtask

    task automatic run(input logic [15:0] ins, input bit hold_s, output int lat);
        @(negedge clk);
        in   = ins;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        lat  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!hold_s || w) s = 1'b0;
        end while (!w && lat < 20);
        s = 1'b0;
    endtask

    task automatic step(input logic [15:0] ins, input bit hold_s);
        int exp_lat, got_lat;
        model_exec(ins, exp_lat);
        run(ins, hold_s, got_lat);
        check($sformatf("lat_%04h", ins), got_lat, exp_lat);
        check($sformatf("out_%04h", ins), out, m_c);
        check($sformatf("nvz_%04h", ins), {N, V, Z}, {m_n, m_v, m_z});
    endtask

    function automatic logic [15:0] rb(input logic [2:0] x);
        return {5'b11000, 3'b000, x, 2'b00, x};
    endfunction

    task automatic dump_regs();
        for (int i = 0; i < 8; i++) step(rb(3'(i)), 1'b0);
    endtask

    initial begin
        logic [15:0] ins;
        int          r;
        reset = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        in    = '0;
        model_reset();
        #12;
        check("rst_w", w, 1'b1);
        check("rst_out", out, 16'd0);
        check("rst_nvz", {N, V, Z}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        dump_regs();

        step(16'hD00A, 1'b0);
        step(rb(3'd0), 1'b0);
        check("r0_is_10", out, 16'd10);
        step(16'hD7FF, 1'b0);
        step(rb(3'd7), 1'b0);
        check("r7_is_ffff", out, 16'hFFFF);
        step(16'hD103, 1'b0);
        step(16'hC041, 1'b0);
        check("mov_r2_r1", out, 16'd3);
        step(16'hA188, 1'b0);
        check("add_lsl", out, 16'd23);
        step(16'hA900, 1'b0);
        check("cmp_r1_r0", {N, V, Z}, 3'b100);
        step(16'hA800, 1'b0);
        check("cmp_r0_r0", {N, V, Z}, 3'b001);
        step(16'hB1A0, 1'b0);
        check("and_r5", out, 16'd2);
        step(16'hB8C0, 1'b0);
        check("mvn_r6", out, 16'hFFF5);
        step(16'hD001, 1'b0);
        for (int i = 0; i < 15; i++) step(16'hC008, 1'b0);
        check("r0_8000", out, 16'h8000);
        step(16'hC078, 1'b0);
        check("asr", out, 16'hC000);
        step(16'hC070, 1'b0);
        check("lsr", out, 16'h4000);
        step(16'hA484, 1'b1);
        dump_regs();

        for (int k = 0; k < 300; k++) begin
            ins = 16'($urandom);
            r   = $urandom_range(0, 9);
            if (r < 3)      ins[15:11] = 5'b11010;
            else if (r < 5) ins[15:11] = 5'b11000;
            else if (r < 9) ins[15:13] = 3'b101;
            step(ins, ($urandom_range(0, 7) == 0));
            if (k % 50 == 49) dump_regs();
        end

        step(16'hD0F3, 1'b0);
        step(16'hC000, 1'b0);
        @(negedge clk);
        in   = 16'hA188;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        s     = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_w", w, 1'b1);
        check("midrst_out", out, 16'd0);
        check("midrst_nvz", {N, V, Z}, 3'b000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        dump_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
